// File: rtl/alu_pipe_if.sv
// Operand-issue and result handshake bundle for alu_pipe.
// The master drives operands and accepts results; the slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   c;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, c, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, c, zero, neg, ovf
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined signed ALU with valid/ready on both sides, status flags
// and an internal accumulator chained through ACC/LOAD beats in issue order.
module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    alu_pipe_if.slave bus
);
    localparam int RW = WIDTH + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_ACC  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [RW-1:0]    c_q, c_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [RW-1:0]    acc_q, acc_d;

    logic             in_ready;
    logic             s1_load;
    logic             s2_load;
    logic [RW-1:0]    sa;
    logic [RW-1:0]    sb;
    logic [RW-1:0]    acc_sum;
    logic             acc_ovf;
    logic [RW-1:0]    alu_res;
    logic             alu_ovf;

    // in_ready looks through to out_ready so a full pipe can still stream.
    assign in_ready = !s1_valid_q || !s2_valid_q || bus.out_ready;
    assign s1_load  = bus.in_valid && in_ready;
    assign s2_load  = s1_valid_q && (!s2_valid_q || bus.out_ready);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_a_d     = bus.a;
            s1_b_d     = bus.b;
            s1_op_d    = bus.opcode;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // Overflow only when both addends share a sign that the sum loses.
    always_comb begin
        sa      = {s1_a_q[WIDTH-1], s1_a_q};
        sb      = {s1_b_q[WIDTH-1], s1_b_q};
        acc_sum = acc_q + sa;
        acc_ovf = (acc_q[RW-1] == sa[RW-1]) && (acc_sum[RW-1] != acc_q[RW-1]);
    end

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (s1_op_q)
            OP_ADD:  alu_res = sa + sb;
            OP_SUB:  alu_res = sa - sb;
            OP_NOT:  alu_res = ~sa;
            OP_ROR:  alu_res = {{WIDTH{1'b0}}, |s1_b_q};
            OP_AND:  alu_res = sa & sb;
            OP_OR:   alu_res = sa | sb;
            OP_ACC: begin
                alu_res = acc_sum;
                alu_ovf = acc_ovf;
            end
            OP_LOAD: alu_res = sa;
            default: alu_res = '0;
        endcase
    end

    // The accumulator only moves when its beat actually advances into stage 2.
    always_comb begin
        acc_d = acc_q;
        if (s2_load && (s1_op_q == OP_ACC || s1_op_q == OP_LOAD)) begin
            acc_d = alu_res;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        c_d        = c_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            c_d        = alu_res;
            zero_d     = (alu_res == '0);
            neg_d      = alu_res[RW-1];
            ovf_d      = alu_ovf;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            c_q        <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            c_q        <= c_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.c         = c_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe, scored against an
// integer-arithmetic reference model with an in-order expectation queue.
module tb_alu_pipe;
    localparam int W = 4;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] NOT  = 3'd2;
    localparam logic [2:0] ROR  = 3'd3;
    localparam logic [2:0] AND  = 3'd4;
    localparam logic [2:0] OR   = 3'd5;
    localparam logic [2:0] ACC  = 3'd6;
    localparam logic [2:0] LOAD = 3'd7;

    typedef struct packed {
        logic [W:0] c;
        logic       z;
        logic       n;
        logic       o;
    } exp_t;

    logic clock;
    logic reset;
    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   m_acc;
    int   compared_count;
    int   mismatch_count;
    logic last_accept;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared_count++;
        assert (obs === exp) else begin
            mismatch_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed integers, wrapped to W+1 bits at the end.
    task automatic model_push(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] op);
        int         sa;
        int         sb;
        int         r;
        logic       o;
        logic [W:0] rc;
        exp_t       e;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        o  = 1'b0;
        r  = 0;
        case (op)
            ADD:  r = sa + sb;
            SUB:  r = sa - sb;
            NOT:  r = -sa - 1;
            ROR:  r = (bv != 0) ? 1 : 0;
            AND:  r = sa & sb;
            OR:   r = sa | sb;
            ACC: begin
                r = m_acc + sa;
                o = (r > (2 ** W) - 1) || (r < -(2 ** W));
            end
            default: r = sa;
        endcase
        rc  = r[W:0];
        e.c = rc;
        e.z = (rc == 0);
        e.n = rc[W];
        e.o = o;
        if (op == ACC || op == LOAD) m_acc = int'($signed(rc));
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        check_val("queue_has_beat", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("model_c", 32'(bus.c), 32'(e.c));
            check_val("model_zero", 32'(bus.zero), 32'(e.z));
            check_val("model_neg", 32'(bus.neg), 32'(e.n));
            check_val("model_ovf", 32'(bus.ovf), 32'(e.o));
        end
    endtask

    // Drive one cycle from the falling edge, score handshakes just before the rising edge.
    task automatic apply_stimulus(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic [2:0] op, input logic ordy);
        bus.in_valid  = v;
        bus.a         = av;
        bus.b         = bv;
        bus.opcode    = op;
        bus.out_ready = ordy;
        #1;
        last_accept = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) check_output();
        if (last_accept) model_push(av, bv, op);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic directed(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic [W:0] ec, input logic ez,
                            input logic en, input logic eo);
        apply_stimulus(1'b1, av, bv, op, 1'b1);
        apply_stimulus(1'b0, '0, '0, ADD, 1'b1);
        check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_val({tag, "_c"}, 32'(bus.c), 32'(ec));
        check_val({tag, "_zero"}, 32'(bus.zero), 32'(ez));
        check_val({tag, "_neg"}, 32'(bus.neg), 32'(en));
        check_val({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        apply_stimulus(1'b0, '0, '0, ADD, 1'b1);
    endtask

    initial begin
        int           k;
        int           drain;
        logic         hold;
        logic         rv;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rop;

        compared_count = 0;
        mismatch_count = 0;
        m_acc          = 0;
        last_accept    = 1'b0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.opcode     = '0;
        bus.out_ready  = 1'b0;

        #2;
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_c", 32'(bus.c), 32'd0);
        check_val("rst_zero", 32'(bus.zero), 32'd0);
        check_val("rst_neg", 32'(bus.neg), 32'd0);
        check_val("rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        directed("add", ADD, 4'd7, 4'd7, 5'b01110, 1'b0, 1'b0, 1'b0);
        directed("sub", SUB, 4'b1000, 4'd7, 5'b10001, 1'b0, 1'b1, 1'b0);
        directed("not", NOT, 4'b0101, 4'd0, 5'b11010, 1'b0, 1'b1, 1'b0);
        directed("ror0", ROR, 4'd3, 4'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        directed("ror8", ROR, 4'd0, 4'b1000, 5'd1, 1'b0, 1'b0, 1'b0);
        directed("and", AND, 4'b1111, 4'd5, 5'd5, 1'b0, 1'b0, 1'b0);
        directed("or", OR, 4'b1000, 4'd1, 5'b11001, 1'b0, 1'b1, 1'b0);

        $display("[TB] accumulator chain");
        apply_stimulus(1'b1, 4'd7, 4'd0, LOAD, 1'b1);
        apply_stimulus(1'b1, 4'd7, 4'd0, ACC, 1'b1);
        check_val("acc1_valid", 32'(bus.out_valid), 32'd1);
        check_val("acc1_c", 32'(bus.c), 32'd7);
        apply_stimulus(1'b1, 4'd7, 4'd0, ACC, 1'b1);
        check_val("acc2_valid", 32'(bus.out_valid), 32'd1);
        check_val("acc2_c", 32'(bus.c), 32'd14);
        check_val("acc2_ovf", 32'(bus.ovf), 32'd0);
        apply_stimulus(1'b0, '0, '0, ADD, 1'b1);
        check_val("acc3_valid", 32'(bus.out_valid), 32'd1);
        check_val("acc3_c", 32'(bus.c), 32'b10101);
        check_val("acc3_ovf", 32'(bus.ovf), 32'd1);
        check_val("acc3_neg", 32'(bus.neg), 32'd1);
        apply_stimulus(1'b0, '0, '0, ADD, 1'b1);

        $display("[TB] backpressure");
        k = 1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, W'(k), 4'd0, ADD, 1'b0);
            if (last_accept) k++;
            if (i >= 1) begin
                check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
                check_val("bp_out_valid", 32'(bus.out_valid), 32'd1);
                check_val("bp_c_hold", 32'(bus.c), 32'd1);
            end
        end
        check_val("bp_accepted", 32'(k - 1), 32'd2);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, W'(k), 4'd0, ADD, 1'b1);
            if (last_accept) k++;
        end
        check_val("bp_stream_accepted", 32'(k - 1), 32'd6);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, '0, ADD, 1'b1);
        check_val("bp_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] asynchronous reset");
        apply_stimulus(1'b1, 4'd5, 4'd1, ADD, 1'b0);
        apply_stimulus(1'b1, 4'd6, 4'd1, SUB, 1'b0);
        bus.in_valid = 1'b0;
        check_val("ar_full_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("ar_full_valid", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("ar_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("ar_c", 32'(bus.c), 32'd0);
        check_val("ar_zero", 32'(bus.zero), 32'd0);
        check_val("ar_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        m_acc = 0;
        @(negedge clock);
        reset = 1'b0;
        apply_stimulus(1'b1, 4'd2, 4'd0, ACC, 1'b1);
        apply_stimulus(1'b0, '0, '0, ADD, 1'b1);
        check_val("ar_acc_cleared", 32'(bus.c), 32'd2);
        apply_stimulus(1'b1, 4'd3, 4'd0, LOAD, 1'b1);
        check_val("ar_load_pending", 32'(bus.out_valid), 32'd0);
        apply_stimulus(1'b0, '0, '0, ADD, 1'b1);
        check_val("ar_load_valid", 32'(bus.out_valid), 32'd1);
        check_val("ar_load_c", 32'(bus.c), 32'd3);
        apply_stimulus(1'b0, '0, '0, ADD, 1'b1);

        $display("[TB] random traffic");
        hold = 1'b0;
        rv   = 1'b0;
        ra   = '0;
        rb   = '0;
        rop  = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                rv  = 1'($urandom_range(0, 1));
                ra  = W'($urandom);
                rb  = W'($urandom);
                rop = 3'($urandom_range(0, 7));
            end
            apply_stimulus(rv, ra, rb, rop, ($urandom_range(0, 3) != 0));
            hold = rv && !last_accept;
        end
        drain = 0;
        while ((exp_q.size() > 0 || bus.out_valid) && drain < 40) begin
            apply_stimulus(1'b0, '0, '0, ADD, 1'b1);
            drain++;
        end
        check_val("rand_drain_queue", 32'(exp_q.size()), 32'd0);
        check_val("rand_drain_idle", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
        $finish;
    end
endmodule
